// File: rtl/traffic_ctrl_mb_responder.sv
// Host mailbox (CMD/ADDRESS/RDDATA/WRDATA) that issues single downstream traffic-controller accesses.
// Optional access timeout is compiled in with `define MB_TIMEOUT_EN.
module traffic_ctrl_mb_responder #(
    parameter int TC_ADDR_W      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           csr_addr,
    input  logic                 csr_wr,
    input  logic [31:0]          csr_wrdata,
    input  logic                 csr_rd,
    output logic [31:0]          csr_rddata,
    output logic                 csr_rdvalid,
    output logic [TC_ADDR_W-1:0] tc_addr,
    output logic                 tc_wr,
    output logic                 tc_rd,
    output logic [31:0]          tc_wrdata,
    input  logic                 tc_waitrequest,
    input  logic [31:0]          tc_rddata,
    input  logic                 tc_rddatavalid
);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_e;

    state_e      state_q;
    logic        ack_q, err_q;
    logic        tc_wr_q, tc_rd_q;
    logic [31:0] addr_q, rddata_q, wrdata_q;
    logic [31:0] csr_rddata_q, csr_rddata_d;
    logic        csr_rdvalid_q;
    logic        busy, rd_pend, wr_pend;
    logic        cmd_wr, addr_wr, wdat_wr;
    logic        expired;

    assign busy    = (state_q != IDLE);
    assign rd_pend = (state_q == RD_REQ) || (state_q == RD_WAIT);
    assign wr_pend = (state_q == WR_REQ);

    // Register writes are dropped entirely while an access is in flight.
    assign cmd_wr  = csr_wr && !busy && (csr_addr == 4'h0);
    assign addr_wr = csr_wr && !busy && (csr_addr == 4'h4);
    assign wdat_wr = csr_wr && !busy && (csr_addr == 4'hC);

    // ADDRESS and WRDATA cannot change while busy, so the downstream bus drives straight from them.
    assign tc_addr     = addr_q[TC_ADDR_W-1:0];
    assign tc_wrdata   = wrdata_q;
    assign tc_wr       = tc_wr_q;
    assign tc_rd       = tc_rd_q;
    assign csr_rddata  = csr_rddata_q;
    assign csr_rdvalid = csr_rdvalid_q;

`ifdef MB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmr_q;

    always_ff @(posedge clk) begin
        if (rst || !busy) tmr_q <= '0;
        else              tmr_q <= tmr_q + 1'b1;
    end

    assign expired = busy && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        csr_rddata_d = 32'h0;
        case (csr_addr)
            4'h0:    csr_rddata_d = {27'b0, err_q, busy, ack_q, wr_pend, rd_pend};
            4'h4:    csr_rddata_d = addr_q;
            4'h8:    csr_rddata_d = rddata_q;
            4'hC:    csr_rddata_d = wrdata_q;
            default: csr_rddata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            tc_wr_q       <= 1'b0;
            tc_rd_q       <= 1'b0;
            addr_q        <= 32'h0;
            rddata_q      <= 32'h0;
            wrdata_q      <= 32'h0;
            csr_rddata_q  <= 32'h0;
            csr_rdvalid_q <= 1'b0;
        end else begin
            // Read data is sampled before this edge's state update, so completion is not visible yet.
            csr_rdvalid_q <= csr_rd;
            if (csr_rd) csr_rddata_q <= csr_rddata_d;
            if (addr_wr) addr_q <= csr_wrdata;
            if (wdat_wr) wrdata_q <= csr_wrdata;

            case (state_q)
                IDLE: begin
                    if (cmd_wr) begin
                        case (csr_wrdata[1:0])
                            2'b00: begin
                                ack_q <= 1'b0;
                                err_q <= 1'b0;
                            end
                            2'b01: begin
                                ack_q   <= 1'b0;
                                err_q   <= 1'b0;
                                tc_rd_q <= 1'b1;
                                state_q <= RD_REQ;
                            end
                            2'b10: begin
                                ack_q   <= 1'b0;
                                err_q   <= 1'b0;
                                tc_wr_q <= 1'b1;
                                state_q <= WR_REQ;
                            end
                            default: ;
                        endcase
                    end
                end
                WR_REQ: begin
                    if (!tc_waitrequest) begin
                        tc_wr_q <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (expired) begin
                        tc_wr_q <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (!tc_waitrequest) begin
                        tc_rd_q <= 1'b0;
                        if (tc_rddatavalid) begin
                            rddata_q <= tc_rddata;
                            ack_q    <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            state_q  <= RD_WAIT;
                        end
                    end else if (expired) begin
                        tc_rd_q  <= 1'b0;
                        rddata_q <= 32'hFFFF_FFFF;
                        ack_q    <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (tc_rddatavalid) begin
                        rddata_q <= tc_rddata;
                        ack_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else if (expired) begin
                        rddata_q <= 32'hFFFF_FFFF;
                        ack_q    <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_mb_responder.sv
// Randomized self-checking bench for traffic_ctrl_mb_responder; expectations come from a mailbox model.
// Timeout scenario is exercised when MB_TIMEOUT_EN is defined, otherwise the indefinite-wait case.
module tb_traffic_ctrl_mb_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  csr_addr = 4'h0;
    logic        csr_wr = 1'b0;
    logic [31:0] csr_wrdata = 32'h0;
    logic        csr_rd = 1'b0;
    logic [31:0] csr_rddata;
    logic        csr_rdvalid;
    logic [15:0] tc_addr;
    logic        tc_wr, tc_rd;
    logic [31:0] tc_wrdata;
    logic        tc_waitrequest = 1'b0;
    logic [31:0] tc_rddata = 32'h0;
    logic        tc_rddatavalid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    // Mailbox model state
    logic [31:0] m_addr = 0, m_wrdata = 0, m_rddata = 0;

    traffic_ctrl_mb_responder #(.TC_ADDR_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .csr_addr(csr_addr), .csr_wr(csr_wr), .csr_wrdata(csr_wrdata),
        .csr_rd(csr_rd), .csr_rddata(csr_rddata), .csr_rdvalid(csr_rdvalid),
        .tc_addr(tc_addr), .tc_wr(tc_wr), .tc_rd(tc_rd), .tc_wrdata(tc_wrdata),
        .tc_waitrequest(tc_waitrequest), .tc_rddata(tc_rddata), .tc_rddatavalid(tc_rddatavalid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tc_wr) begin wr_cnt++; wr_addr = tc_addr; wr_data = tc_wrdata; end
        if (tc_rd) rd_cnt++;
        if (tc_wr && tc_rd) both_cnt++;
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        csr_wr = 1'b1; csr_addr = a; csr_wrdata = d;
        @(negedge clk);
        csr_wr = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d, output logic v);
        csr_rd = 1'b1; csr_addr = a;
        @(negedge clk);
        csr_rd = 1'b0;
        d = csr_rddata; v = csr_rdvalid;
    endtask

    // Downstream read handshake: waitrequest high for w cycles, data l cycles after acceptance.
    task automatic serve_read(input int w, input int l, input logic [31:0] d);
        repeat (w) @(negedge clk);
        tc_waitrequest = 1'b0;
        if (l > 0) begin
            @(negedge clk);
            repeat (l - 1) @(negedge clk);
        end
        tc_rddatavalid = 1'b1; tc_rddata = d;
        @(negedge clk);
        tc_rddatavalid = 1'b0; tc_rddata = $urandom;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tc_wr !== 1'b0 || tc_rd !== 1'b0) begin n_fail++; $display("FAIL reset_tc: wr=%b rd=%b required 0 0", tc_wr, tc_rd); end
        n_checks++; if (csr_rdvalid !== 1'b0 || csr_rddata !== 32'h0) begin n_fail++; $display("FAIL reset_csr: valid=%b data=%h required 0 0", csr_rdvalid, csr_rddata); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            csr_read(4'(i * 4), d, v);
            n_checks++; if (d !== 32'h0 || v !== 1'b1) begin n_fail++; $display("FAIL reset_reg%0d: got %h valid %b required 0 valid 1", i, d, v); end
        end
        @(negedge clk);
        n_checks++; if (csr_rdvalid !== 1'b0) begin n_fail++; $display("FAIL rdvalid_pulse: got %b required 0", csr_rdvalid); end
    endtask

    task automatic test_write_basic;
        logic [31:0] d; logic v;
        csr_write(4'h4, 32'h200); m_addr = 32'h200;
        csr_write(4'hC, 32'h1);   m_wrdata = 32'h1;
        wr_cnt = 0;
        csr_write(4'h0, 32'h2);
        @(negedge clk);
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL wr_pulse: got %0d cycles required 1", wr_cnt); end
        n_checks++; if (wr_addr !== 16'h200 || wr_data !== 32'h1) begin n_fail++; $display("FAIL wr_bus: addr %h data %h required 0200 00000001", wr_addr, wr_data); end
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL wr_cmd: got %h required 4", d); end
    endtask

    task automatic test_read_basic;
        logic [31:0] d; logic v;
        csr_write(4'h4, 32'h101); m_addr = 32'h101;
        rd_cnt = 0; tc_waitrequest = 1'b1;
        csr_write(4'h0, 32'h1);
        serve_read(3, 2, 32'h1234); m_rddata = 32'h1234;
        n_checks++; if (rd_cnt !== 4) begin n_fail++; $display("FAIL rd_hold: got %0d cycles required 4", rd_cnt); end
        csr_read(4'h8, d, v);
        n_checks++; if (d !== 32'h1234) begin n_fail++; $display("FAIL rd_data: got %h required 1234", d); end
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL rd_cmd: got %h required 4", d); end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] d; logic v;
        csr_write(4'h4, 32'h77); m_addr = 32'h77;
        wr_cnt = 0; tc_waitrequest = 1'b1;
        csr_write(4'h0, 32'h2);
        csr_write(4'h4, 32'h5);
        csr_write(4'h0, 32'h2);
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'hA) begin n_fail++; $display("FAIL busy_cmd: got %h required a", d); end
        tc_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_cnt !== 4 || wr_addr !== 16'h77) begin n_fail++; $display("FAIL busy_wr: cycles %0d addr %h required 4 0077", wr_cnt, wr_addr); end
        csr_read(4'h4, d, v);
        n_checks++; if (d !== 32'h77) begin n_fail++; $display("FAIL busy_addr: got %h required 77", d); end
    endtask

    task automatic test_cmd_codes;
        logic [31:0] d; logic v;
        wr_cnt = 0; rd_cnt = 0;
        csr_write(4'h0, 32'h3);
        @(negedge clk);
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h4 || wr_cnt !== 0 || rd_cnt !== 0) begin n_fail++; $display("FAIL cmd_11: cmd %h wr %0d rd %0d required 4 0 0", d, wr_cnt, rd_cnt); end
        csr_write(4'h0, 32'h0);
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL cmd_noop: got %h required 0", d); end
        csr_read(4'h6, d, v);
        n_checks++; if (d !== 32'h0 || v !== 1'b1) begin n_fail++; $display("FAIL unmapped: got %h valid %b required 0 1", d, v); end
    endtask

    task automatic test_simultaneous;
        logic [31:0] d; logic v;
        // Same-cycle write and read of ADDRESS: read sees the old contents
        csr_wr = 1'b1; csr_wrdata = 32'hBEEF; csr_rd = 1'b1; csr_addr = 4'h4;
        @(negedge clk);
        csr_wr = 1'b0; csr_rd = 1'b0;
        n_checks++; if (csr_rddata !== m_addr) begin n_fail++; $display("FAIL simul_addr: got %h required %h", csr_rddata, m_addr); end
        m_addr = 32'hBEEF;
        tc_waitrequest = 1'b0;
        csr_write(4'h0, 32'h1);
        @(negedge clk);
        // Completion edge coincides with a CMD read
        tc_rddatavalid = 1'b1; tc_rddata = 32'h55AA; csr_rd = 1'b1; csr_addr = 4'h0;
        @(negedge clk);
        tc_rddatavalid = 1'b0; csr_rd = 1'b0; m_rddata = 32'h55AA;
        n_checks++; if (csr_rddata !== 32'h9) begin n_fail++; $display("FAIL simul_cmd: got %h required 9", csr_rddata); end
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL simul_done: got %h required 4", d); end
    endtask

    task automatic test_random;
        logic [31:0] d, a, wd, rdv; logic v;
        int w, l, is_wr;
        for (int it = 0; it < 24; it++) begin
            a = $urandom; wd = $urandom; rdv = $urandom;
            w = $urandom_range(0, 3); l = $urandom_range(0, 3); is_wr = $urandom_range(0, 1);
            csr_write(4'h4, a); m_addr = a;
            csr_write(4'hC, wd); m_wrdata = wd;
            wr_cnt = 0; rd_cnt = 0;
            tc_waitrequest = (w != 0);
            if (is_wr != 0) begin
                csr_write(4'h0, 32'h2);
                repeat (w) @(negedge clk);
                tc_waitrequest = 1'b0;
                @(negedge clk);
                n_checks++; if (wr_cnt !== w + 1 || rd_cnt !== 0 || wr_addr !== a[15:0] || wr_data !== wd) begin n_fail++; $display("FAIL rnd_wr%0d: cyc %0d addr %h data %h required %0d %h %h", it, wr_cnt, wr_addr, wr_data, w + 1, a[15:0], wd); end
            end else begin
                csr_write(4'h0, 32'h1);
                serve_read(w, l, rdv); m_rddata = rdv;
                n_checks++; if (rd_cnt !== w + 1 || wr_cnt !== 0) begin n_fail++; $display("FAIL rnd_rd%0d: rd cyc %0d wr cyc %0d required %0d 0", it, rd_cnt, wr_cnt, w + 1); end
            end
            csr_read(4'h8, d, v);
            n_checks++; if (d !== m_rddata) begin n_fail++; $display("FAIL rnd_rddata%0d: got %h required %h", it, d, m_rddata); end
            csr_read(4'h0, d, v);
            n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL rnd_cmd%0d: got %h required 4", it, d); end
            csr_read(4'h4, d, v);
            n_checks++; if (d !== m_addr) begin n_fail++; $display("FAIL rnd_addr%0d: got %h required %h", it, d, m_addr); end
            csr_read(4'hC, d, v);
            n_checks++; if (d !== m_wrdata) begin n_fail++; $display("FAIL rnd_wrdata%0d: got %h required %h", it, d, m_wrdata); end
        end
    endtask

    task automatic test_reset_mid_access;
        logic [31:0] d; logic v;
        csr_write(4'h4, 32'h33);
        tc_waitrequest = 1'b0;
        csr_write(4'h0, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (tc_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rdwait_tc: got %b required 0", tc_rd); end
        tc_rddatavalid = 1'b1; tc_rddata = 32'hABCD;
        @(negedge clk);
        tc_rddatavalid = 1'b0;
        csr_read(4'h8, d, v);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_rddata: got %h required 0", d); end
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_cmd: got %h required 0", d); end
        tc_waitrequest = 1'b1;
        csr_write(4'h0, 32'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (tc_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wrreq_tc: got %b required 0", tc_wr); end
        tc_waitrequest = 1'b0;
        m_addr = 0; m_wrdata = 0; m_rddata = 0;
    endtask

    task automatic test_stall;
        logic [31:0] d; logic v;
        tc_waitrequest = 1'b1; rd_cnt = 0;
        csr_write(4'h0, 32'h1);
`ifdef MB_TIMEOUT_EN
        for (int i = 0; i < 40 && tc_rd; i++) @(negedge clk);
        n_checks++; if (rd_cnt !== 16 || tc_rd !== 1'b0) begin n_fail++; $display("FAIL tmo_hold: cycles %0d rd %b required 16 0", rd_cnt, tc_rd); end
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h14) begin n_fail++; $display("FAIL tmo_cmd: got %h required 14", d); end
        csr_read(4'h8, d, v);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tmo_rddata: got %h required ffffffff", d); end
        tc_waitrequest = 1'b0;
        csr_write(4'h0, 32'h0);
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL tmo_noop: got %h required 0", d); end
`else
        repeat (40) @(negedge clk);
        n_checks++; if (tc_rd !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got %b required 1", tc_rd); end
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h9) begin n_fail++; $display("FAIL stall_cmd: got %h required 9", d); end
        serve_read(0, 1, 32'hC0DE);
        csr_read(4'h0, d, v);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL stall_done: got %h required 4", d); end
        csr_read(4'h8, d, v);
        n_checks++; if (d !== 32'hC0DE) begin n_fail++; $display("FAIL stall_data: got %h required c0de", d); end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_write_basic;
        test_read_basic;
        test_busy_ignore;
        test_cmd_codes;
        test_simultaneous;
        test_random;
        test_reset_mid_access;
        test_stall;
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL excl: tc_wr&tc_rd seen %0d cycles required 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
